// File: rtl/stream_perf_monitor.sv
// Passive per-channel valid/ready monitor: beat/stall counters, first/last-beat timestamps, snapshot readback.
// rd_data and snap_valid are registered (one cycle); the taps never exert backpressure on the observed streams.
module stream_perf_monitor #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 32,
  parameter int SATURATE  = 1
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [NUM_CH-1:0]    valid,
  input  logic [NUM_CH-1:0]    ready,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 snap,
  input  logic [3:0]           rd_ch,
  input  logic [1:0]           rd_kind,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic                 snap_valid,
  output logic [CNT_WIDTH-1:0] timer,
  output logic [NUM_CH-1:0]    ovf
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  localparam cnt_t ALL_ONES = '1;

  cnt_t beats      [NUM_CH];
  cnt_t stalls     [NUM_CH];
  cnt_t first_ts   [NUM_CH];
  cnt_t last_ts    [NUM_CH];
  logic [NUM_CH-1:0] seen;

  cnt_t snap_beats [NUM_CH];
  cnt_t snap_stalls[NUM_CH];
  cnt_t snap_first [NUM_CH];
  cnt_t snap_last  [NUM_CH];

  logic [NUM_CH-1:0] beat_hit;
  logic [NUM_CH-1:0] stall_hit;
  logic [NUM_CH-1:0] beat_wrap;
  logic [NUM_CH-1:0] stall_wrap;
  cnt_t              beats_nx [NUM_CH];
  cnt_t              stalls_nx[NUM_CH];
  cnt_t              timer_nx;
  cnt_t              rd_sel;

  // One step of a counter at all-ones either sticks there or rolls to zero.
  function automatic cnt_t bump(input cnt_t v);
    if (v == ALL_ONES) return (SATURATE != 0) ? ALL_ONES : '0;
    return v + cnt_t'(1);
  endfunction

  assign beat_hit  = valid &  ready & {NUM_CH{enable}};
  assign stall_hit = valid & ~ready & {NUM_CH{enable}};

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      beats_nx[i]   = beat_hit[i]  ? bump(beats[i])  : beats[i];
      stalls_nx[i]  = stall_hit[i] ? bump(stalls[i]) : stalls[i];
      beat_wrap[i]  = beat_hit[i]  && (beats[i]  == ALL_ONES);
      stall_wrap[i] = stall_hit[i] && (stalls[i] == ALL_ONES);
    end
    timer_nx = enable ? bump(timer) : timer;
  end

  // Live counters; clear outranks any beat or stall seen in the same cycle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      timer <= '0;
      ovf   <= '0;
      seen  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        beats[i]    <= '0;
        stalls[i]   <= '0;
        first_ts[i] <= ALL_ONES;
        last_ts[i]  <= ALL_ONES;
      end
    end else if (clear) begin
      timer <= '0;
      ovf   <= '0;
      seen  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        beats[i]    <= '0;
        stalls[i]   <= '0;
        first_ts[i] <= ALL_ONES;
        last_ts[i]  <= ALL_ONES;
      end
    end else begin
      timer <= timer_nx;
      ovf   <= ovf | beat_wrap | stall_wrap;
      seen  <= seen | beat_hit;
      for (int i = 0; i < NUM_CH; i++) begin
        beats[i]  <= beats_nx[i];
        stalls[i] <= stalls_nx[i];
        if (beat_hit[i]) begin
          last_ts[i] <= timer;
          if (!seen[i]) first_ts[i] <= timer;
        end
      end
    end
  end

  // Channels past NUM_CH fall through to the zero default.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == 4'(i)) begin
        case (rd_kind)
          2'd0: rd_sel = snap_beats[i];
          2'd1: rd_sel = snap_stalls[i];
          2'd2: rd_sel = snap_first[i];
          2'd3: rd_sel = snap_last[i];
        endcase
      end
    end
  end

  // Snapshot bank copies the pre-edge live registers and is immune to clear.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      snap_valid <= 1'b0;
      rd_data    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_beats[i]  <= '0;
        snap_stalls[i] <= '0;
        snap_first[i]  <= ALL_ONES;
        snap_last[i]   <= ALL_ONES;
      end
    end else begin
      snap_valid <= snap;
      rd_data    <= rd_sel;
      if (snap) begin
        for (int i = 0; i < NUM_CH; i++) begin
          snap_beats[i]  <= beats[i];
          snap_stalls[i] <= stalls[i];
          snap_first[i]  <= first_ts[i];
          snap_last[i]   <= last_ts[i];
        end
      end
    end
  end

endmodule
